ram_access_arbiter: RTL and testbench

Arbitrates the single-port image RAM (8-bit address, 16-bit data) between the host loader, which writes source pixels and reads results, and the PROCE_COMP processor core. Ownership of the RAM port is gated by the `pro_select` mode input. It uses a two-requester round-robin with a burst limit and tags read returns. It sits between both requesters and the RAM macro and replaces the direct processor-to-RAM wiring.

---
 rtl/img_ram_pkg.sv | 19 +
 rtl/ram_access_arbiter.sv | 145 ++++++++++++++
 tb/tb_ram_access_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/img_ram_pkg.sv
// Shared types for the image RAM access path.
// Default widths, arbiter state and owner tags.
package img_ram_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOST,
    ST_PROC
  } arb_state_t;

  typedef enum logic {
    OWN_HOST,
    OWN_PROC
  } owner_t;

endpackage

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter for the single-port image RAM.
// Host loader vs processor, burst-limited tenures, tagged read returns.
module ram_access_arbiter
  import img_ram_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pro_select,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              proc_req,
  input  logic              proc_we,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_wdata,
  output logic              proc_gnt,
  output logic              proc_rvalid,
  output logic [DATA_W-1:0] proc_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  arb_state_t        state;
  owner_t            last_owner;
  owner_t            rd_tag;
  logic              rd_pend;
  logic [CW-1:0]     burst_cnt;

  logic              proc_req_m;
  logic              own_host;
  logic              own_proc;
  logic              own_req;
  logic              own_we;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic              other_req;
  logic              accept;
  logic              burst_last;
  arb_state_t        other_st;
  owner_t            cur_owner;

  assign proc_req_m = proc_req & pro_select;
  assign own_host   = (state == ST_HOST);
  assign own_proc   = (state == ST_PROC);

  always_comb begin
    own_req   = 1'b0;
    own_we    = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    other_req = 1'b0;
    unique case (1'b1)
      own_host: begin
        own_req   = host_req;
        own_we    = host_we;
        own_addr  = host_addr;
        own_wdata = host_wdata;
        other_req = proc_req_m;
      end
      own_proc: begin
        own_req   = proc_req_m;
        own_we    = proc_we;
        own_addr  = proc_addr;
        own_wdata = proc_wdata;
        other_req = host_req;
      end
      default: ;
    endcase
  end

  // Grants never depend on ram_rdata; reset blanks them at once.
  assign host_gnt   = rst_n & own_host & host_req;
  assign proc_gnt   = rst_n & own_proc & proc_req_m;
  assign accept     = host_gnt | proc_gnt;
  assign burst_last = (burst_cnt == CNT_LAST);
  assign other_st   = own_host ? ST_PROC : ST_HOST;
  assign cur_owner  = own_host ? OWN_HOST : OWN_PROC;

  assign ram_en    = accept;
  assign ram_we    = accept & own_we;
  assign ram_addr  = own_addr;
  assign ram_wdata = own_wdata;

  assign host_rdata  = ram_rdata;
  assign proc_rdata  = ram_rdata;
  assign host_rvalid = rst_n & rd_pend & (rd_tag == OWN_HOST);
  assign proc_rvalid = rst_n & rd_pend & (rd_tag == OWN_PROC);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      burst_cnt  <= '0;
      last_owner <= OWN_PROC;
      rd_pend    <= 1'b0;
      rd_tag     <= OWN_HOST;
    end else begin
      rd_pend <= accept & ~own_we;
      if (accept) rd_tag <= cur_owner;
      unique case (state)
        ST_IDLE: begin
          burst_cnt <= '0;
          if (host_req &&
              (!proc_req_m || last_owner == OWN_PROC))
            state <= ST_HOST;
          else if (proc_req_m)
            state <= ST_PROC;
        end
        ST_HOST, ST_PROC: begin
          if ((accept && burst_last && other_req) ||
              (!own_req && other_req)) begin
            state      <= other_st;
            burst_cnt  <= '0;
            last_owner <= cur_owner;
          end else if (!own_req) begin
            state      <= ST_IDLE;
            burst_cnt  <= '0;
            last_owner <= cur_owner;
          end else if (accept && !burst_last) begin
            // Saturates so a late requester still preempts.
            burst_cnt <= burst_cnt + CW'(1);
          end
        end
        default: begin
          state     <= ST_IDLE;
          burst_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Self-checking bench for ram_access_arbiter.
// RAM model plus read-return scoreboard.
module tb_ram_access_arbiter;

  logic        clk;
  logic        rst_n;
  logic        pro_select;
  logic        host_req, host_we, host_gnt, host_rvalid;
  logic [7:0]  host_addr;
  logic [15:0] host_wdata, host_rdata;
  logic        proc_req, proc_we, proc_gnt, proc_rvalid;
  logic [7:0]  proc_addr;
  logic [15:0] proc_wdata, proc_rdata;
  logic        ram_en, ram_we;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata, ram_rdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          due;
    bit          side;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mem[256];
  logic [15:0] ref_mem[256];

  ram_access_arbiter #(
    .ADDR_W(8), .DATA_W(16), .MAX_BURST(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pro_select(pro_select),
    .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata),
    .proc_req(proc_req), .proc_we(proc_we),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_gnt(proc_gnt), .proc_rvalid(proc_rvalid),
    .proc_rdata(proc_rdata),
    .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end
  end

  // Scoreboard: reads pushed at acceptance, popped one cycle later.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      total++;
      if (host_rvalid !== 1'b0 || proc_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL rvalid_in_reset: h=%b p=%b want 0 0",
                 host_rvalid, proc_rvalid);
      end
    end else begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        total++;
        if (host_rvalid !== !e.side || proc_rvalid !== e.side ||
            (e.side ? proc_rdata : host_rdata) !== e.data) begin
          bad++;
          $display("FAIL rd_return: h=%b p=%b hd=%h pd=%h want side=%0d data=%h",
                   host_rvalid, proc_rvalid, host_rdata, proc_rdata,
                   e.side, e.data);
        end
      end else begin
        total++;
        if (host_rvalid !== 1'b0 || proc_rvalid !== 1'b0) begin
          bad++;
          $display("FAIL spurious_rvalid: h=%b p=%b want 0 0",
                   host_rvalid, proc_rvalid);
        end
      end
      if (host_req && host_gnt) begin
        if (host_we) ref_mem[host_addr] = host_wdata;
        else exp_q.push_back('{cyc + 1, 1'b0, ref_mem[host_addr]});
      end
      if (proc_req && proc_gnt) begin
        if (proc_we) ref_mem[proc_addr] = proc_wdata;
        else exp_q.push_back('{cyc + 1, 1'b1, ref_mem[proc_addr]});
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input bit side);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((side ? proc_gnt : host_gnt) === 1'b1) return;
      nxt();
    end
    total++;
    bad++;
    $display("FAIL gnt_timeout: side=%0d no grant in 20 cycles", side);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (host_gnt !== 1'b0 || proc_gnt !== 1'b0 || ram_en !== 1'b0) begin
        bad++;
        $display("FAIL reset_outs: hg=%b pg=%b en=%b want 0 0 0",
                 host_gnt, proc_gnt, ram_en);
      end
      nxt();
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (host_gnt !== 1'b0 || proc_gnt !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_c1: hg=%b pg=%b want 0 0",
               host_gnt, proc_gnt);
    end
    nxt();
    @(negedge clk);
    total++;
    if (host_gnt !== 1'b1 || proc_gnt !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_c2: hg=%b pg=%b want 1 0",
               host_gnt, proc_gnt);
    end
    nxt();
    host_req = 1'b0;
    proc_req = 1'b0;
    nxt();
    nxt();
  endtask

  task automatic test_host_wr_rd();
    host_req   = 1'b1;
    host_we    = 1'b1;
    host_addr  = 8'h10;
    host_wdata = 16'hA5A5;
    wait_gnt(1'b0);
    total++;
    if (ram_en !== 1'b1 || ram_we !== 1'b1 ||
        ram_addr !== 8'h10 || ram_wdata !== 16'hA5A5) begin
      bad++;
      $display("FAIL host_write: en=%b we=%b a=%h d=%h want 1 1 10 a5a5",
               ram_en, ram_we, ram_addr, ram_wdata);
    end
    nxt();
    host_we = 1'b0;
    @(negedge clk);
    total++;
    if (host_gnt !== 1'b1 || ram_we !== 1'b0) begin
      bad++;
      $display("FAIL host_read_gnt: gnt=%b we=%b want 1 0",
               host_gnt, ram_we);
    end
    nxt();
    host_req = 1'b0;
    @(negedge clk);
    total++;
    if (host_rvalid !== 1'b1 || host_rdata !== 16'hA5A5) begin
      bad++;
      $display("FAIL host_read_data: rv=%b d=%h want 1 a5a5",
               host_rvalid, host_rdata);
    end
    nxt();
    nxt();
  endtask

  task automatic test_mode_gate();
    bit got;
    pro_select = 1'b0;
    proc_req   = 1'b1;
    proc_we    = 1'b0;
    proc_addr  = 8'h30;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      total++;
      if (proc_gnt !== 1'b0) begin
        bad++;
        $display("FAIL mode_gate: cycle=%0d pg=%b want 0", i, proc_gnt);
      end
      nxt();
    end
    pro_select = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 2 && !got; i++) begin
      @(negedge clk);
      if (proc_gnt === 1'b1) got = 1'b1;
      nxt();
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL mode_enable: pg never 1 want 1 within 2 cycles");
    end
    proc_req = 1'b0;
    nxt();
    nxt();
  endtask

  task automatic test_burst();
    bit eh;
    host_req   = 1'b1;
    host_we    = 1'b1;
    host_addr  = 8'h40;
    host_wdata = 16'h1111;
    proc_req   = 1'b1;
    proc_we    = 1'b1;
    proc_addr  = 8'h41;
    proc_wdata = 16'h2222;
    wait_gnt(1'b0);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) begin
        nxt();
        host_wdata = 16'(16'h1000 + i);
        proc_wdata = 16'(16'h2000 + i);
        @(negedge clk);
      end
      eh = (i < 4) || (i >= 8);
      total++;
      if (host_gnt !== eh || proc_gnt !== !eh) begin
        bad++;
        $display("FAIL burst: slot=%0d hg=%b pg=%b want %b %b",
                 i, host_gnt, proc_gnt, eh, !eh);
      end
    end
    nxt();
    host_req = 1'b0;
    proc_req = 1'b0;
    nxt();
    nxt();
  endtask

  task automatic test_tag_switch();
    proc_req   = 1'b1;
    proc_we    = 1'b1;
    proc_addr  = 8'h20;
    proc_wdata = 16'h1234;
    wait_gnt(1'b1);
    for (int i = 1; i < 4; i++) begin
      nxt();
      proc_addr  = 8'(8'h20 + i);
      proc_wdata = 16'(16'h0100 + i);
      if (i == 3) begin
        proc_we   = 1'b0;
        proc_addr = 8'h20;
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 8'h10;
      end
      @(negedge clk);
      total++;
      if (proc_gnt !== 1'b1 || host_gnt !== 1'b0) begin
        bad++;
        $display("FAIL tag_tenure: acc=%0d pg=%b hg=%b want 1 0",
                 i, proc_gnt, host_gnt);
      end
    end
    nxt();
    proc_req = 1'b0;
    @(negedge clk);
    total++;
    if (host_gnt !== 1'b1 || proc_rvalid !== 1'b1 ||
        proc_rdata !== 16'h1234 || host_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL tag_switch: hg=%b prv=%b pd=%h hrv=%b want 1 1 1234 0",
               host_gnt, proc_rvalid, proc_rdata, host_rvalid);
    end
    nxt();
    host_req = 1'b0;
    nxt();
    nxt();
  endtask

  task automatic test_reset_mid_read();
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = 8'h11;
    wait_gnt(1'b0);
    nxt();
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (host_rvalid !== 1'b0 || host_gnt !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: hrv=%b hg=%b want 0 0",
               host_rvalid, host_gnt);
    end
    nxt();
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (host_gnt !== 1'b0 || ram_en !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: hg=%b en=%b want 0 0",
               host_gnt, ram_en);
    end
    nxt();
    @(negedge clk);
    total++;
    if (host_gnt !== 1'b1) begin
      bad++;
      $display("FAIL regrant_after_reset: hg=%b want 1", host_gnt);
    end
    nxt();
    host_req = 1'b0;
    nxt();
    nxt();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 16'(i * 3 + 16'h0500);
      ref_mem[i] = 16'(i * 3 + 16'h0500);
    end
    ram_rdata  = '0;
    rst_n      = 1'b0;
    pro_select = 1'b1;
    host_req   = 1'b1;
    host_we    = 1'b0;
    host_addr  = 8'h00;
    host_wdata = '0;
    proc_req   = 1'b1;
    proc_we    = 1'b0;
    proc_addr  = 8'h01;
    proc_wdata = '0;
    #1;
    test_reset();
    test_host_wr_rd();
    test_mode_gate();
    test_burst();
    test_tag_switch();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
